mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter sharing the single-port instruction/data RAM between the CPU memory port and a secondary requester (program loader / I/O DMA). Each cycle it grants at most one pending access, registers the winning command onto the RAM port, and routes read data back with a per-port valid strobe. Round-robin fairness, plus an optional bounded lock for back-to-back bursts. Sits between `cpu` (mem_cmd/mem_addr/write_data/read_data) and the RAM.

## Interface
- `AW`, 9, address width
- `DW`, 16, data width
- `RD_LAT`, 1, RAM read latency in cycles from registered `mem_cmd`=MREAD to valid `mem_rdata` (1..4)
- `LOCK_MAX`, 8, maximum consecutive grants under lock (2..255)

- `clk` in 1 — single clock, all flops rising edge
- `reset` in 1 — asynchronous, active-low
- `req0`/`req1` in 1 — access request; held until `gntN`
- `cmd0`/`cmd1` in 2 — MREAD 2'b01, MWRITE 2'b10; MNONE 2'b00 or 2'b11 is never granted
- `addr0`/`addr1` in AW — access address
- `wdata0`/`wdata1` in DW — write data
- `lock0`/`lock1` in 1 — request to keep ownership after this grant
- `gnt0`/`gnt1` out 1 — access accepted this cycle (combinational)
- `rvalid0`/`rvalid1` out 1 — `rdata` is this port's read return
- `rdata` out DW — read data to both ports
- `mem_cmd` out 2, `mem_addr` out AW, `mem_wdata` out DW — registered RAM command
- `mem_rdata` in DW — RAM read data

## Operation
- Eligible port N: `reqN`=1 and `cmdN` ∈ {MREAD, MWRITE}.
- State `ARB`: one eligible → grant it; both → grant port at `ptr`. After each grant `ptr` ← other port.
- `ptr` reset value 0 (CPU wins the first tie).
- Grant with `lockN`=1 (macro on) → state `LOCKN`, `lock_cnt` ← 1. In `LOCKN` only port N is eligible; each further grant increments `lock_cnt`.
- Exit `LOCKN` → `ARB` when port N is granted with `lockN`=0, when `lock_cnt` reaches `LOCK_MAX` (that grant is the last), or when port N has no eligible request for one cycle. On exit `ptr` ← other port.
- Granted access registered: `mem_cmd/addr/wdata` ← winner's values next cycle; no grant → `mem_cmd` ← MNONE, addr/wdata hold.
- Read tag (valid + port id) enters an RD_LAT-deep shift pipe when MREAD is issued; at the output, `rvalidN` = tag valid && id==N and `rdata` = `mem_rdata` (combinational pass-through).
- Writes produce no return.

## Timing
- Cycle T: `gntN`=1. T+1: `mem_cmd` issued. T+1+RD_LAT: `rvalidN` with data.
- Throughput one access per cycle; reads pipelined, no bubbles between ports.
- Read-after-write to same address on consecutive grants returns new data (RAM ordering, no arbiter hazard logic).
- Reset asserted: `gnt0/1` forced 0 combinationally; `mem_cmd`=MNONE, `mem_addr`=0, `mem_wdata`=0, `rvalid0/1`=0, state `ARB`, `ptr`=0, `lock_cnt`=0. Reset mid-read discards all in-flight tags; no `rvalid` after deassertion for pre-reset reads.
- `lock_cnt` never wraps; saturates at LOCK_MAX and forces exit.
- `reqN` dropped without grant: no effect.

## Configuration
- `MEM_ARBITER_LOCK_EN` defined: `lock0/1` and `LOCK0/LOCK1` states, `lock_cnt` present as above.
- Undefined: lock ports exist but are ignored; FSM is `ARB` only; pure round-robin.

## Structure
- Package `mem_arb_pkg`: MNONE/MREAD/MWRITE constants, arbiter state encoding (ARB, LOCK0, LOCK1), read-tag type (valid, port id).
- Sub-module `rd_tag_pipe`: RD_LAT-stage tag shift register with async active-low clear.

## Test plan
- Both ports request MREAD at reset release, addrs 9'h010/9'h020 → `gnt0` at T, `gnt1` at T+1, `rvalid0` with RAM[0x010] at T+2, `rvalid1` with RAM[0x020] at T+3 (RD_LAT=1).
- Continuous requests on both ports for 10 cycles → grants alternate 0,1,0,1…; 5 grants each.
- Port 1 writes 16'hBEEF to 9'h005, then port 0 reads 9'h005 → `rdata`=16'hBEEF with `rvalid0`.
- Macro on, LOCK_MAX=4, port 1 holds `lock1`=1 with port 0 requesting → port 1 granted 4 consecutive, then port 0 granted.
- Port 0 `cmd0`=2'b00 with `req0`=1, port 1 idle → no grant, `mem_cmd`=MNONE.
- RD_LAT=3, read issued, reset pulsed low 1 cycle later → all outputs at reset values, no `rvalid` afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: RAM command encodings, arbiter state encoding and read-tag type
// shared by mem_arbiter and its read-tag pipe.
package mem_arb_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

  // 2'b00 and 2'b11 are both "no access" and must never win arbitration.
  function automatic logic cmd_is_access(input logic [1:0] cmd);
    return (cmd == MREAD) || (cmd == MWRITE);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: STAGES-deep shift register carrying read tags (valid + port id)
// alongside the RAM read latency; the async clear drops all in-flight tags.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_pipe [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[STAGES-1];

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between two requesters.
// Define MEM_ARBITER_LOCK_EN to honour lock0/lock1 bounded burst ownership.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [1:0]    cmd0,
  input  logic [1:0]    cmd1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic w_elig0, w_elig1, w_e0, w_e1;
  logic w_pick1, w_gnt0, w_gnt1, w_any;
  logic w_lock_idle, w_idle_ptr;
  logic r_ptr;
  logic [1:0]    r_mem_cmd;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_id;
  rd_tag_t       w_tag_in, w_tag_out;

  assign w_elig0 = req0 && cmd_is_access(cmd0);
  assign w_elig1 = req1 && cmd_is_access(cmd1);

`ifdef MEM_ARBITER_LOCK_EN
  localparam logic [7:0] LC_LAST = 8'(LOCK_MAX - 1);

  arb_state_t r_state;
  logic [7:0] r_lock_cnt;

  assign w_e0 = w_elig0 && (r_state != LOCK1);
  assign w_e1 = w_elig1 && (r_state != LOCK0);
  // A lock owner that goes quiet for a cycle releases and hands priority over.
  assign w_lock_idle = (r_state != ARB) && !w_any;
  assign w_idle_ptr  = (r_state == LOCK0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_lock_cnt <= '0;
    end else begin
      unique case (r_state)
        ARB: begin
          if (w_gnt0 && lock0) begin
            r_state    <= LOCK0;
            r_lock_cnt <= 8'd1;
          end else if (w_gnt1 && lock1) begin
            r_state    <= LOCK1;
            r_lock_cnt <= 8'd1;
          end
        end
        LOCK0: begin
          if (w_gnt0) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
            if (!lock0 || (r_lock_cnt >= LC_LAST)) r_state <= ARB;
          end else begin
            r_state <= ARB;
          end
        end
        LOCK1: begin
          if (w_gnt1) begin
            r_lock_cnt <= r_lock_cnt + 8'd1;
            if (!lock1 || (r_lock_cnt >= LC_LAST)) r_state <= ARB;
          end else begin
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end
`else
  logic w_unused_lock;

  assign w_e0          = w_elig0;
  assign w_e1          = w_elig1;
  assign w_lock_idle   = 1'b0;
  assign w_idle_ptr    = 1'b0;
  assign w_unused_lock = lock0 | lock1;
`endif

  // r_ptr names the port that wins a tie; grants are suppressed while in reset.
  assign w_pick1 = w_e1 && (!w_e0 || r_ptr);
  assign w_gnt1  = reset && w_pick1;
  assign w_gnt0  = reset && w_e0 && !w_pick1;
  assign w_any   = w_gnt0 || w_gnt1;
  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= 1'b0;
      r_mem_cmd   <= MNONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_id    <= 1'b0;
    end else if (w_any) begin
      r_ptr       <= w_gnt0;
      r_mem_cmd   <= w_gnt1 ? cmd1   : cmd0;
      r_mem_addr  <= w_gnt1 ? addr1  : addr0;
      r_mem_wdata <= w_gnt1 ? wdata1 : wdata0;
      r_mem_id    <= w_gnt1;
    end else begin
      r_mem_cmd <= MNONE;
      if (w_lock_idle) r_ptr <= w_idle_ptr;
    end
  end

  assign mem_cmd   = r_mem_cmd;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Tags enter as the read is presented to the RAM, so RD_LAT stages line up with mem_rdata.
  assign w_tag_in.vld = (r_mem_cmd == MREAD);
  assign w_tag_in.id  = r_mem_id;

  rd_tag_pipe #(.STAGES(RD_LAT)) u_tag_pipe (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_tag   (w_tag_in),
    .o_tag   (w_tag_out)
  );

  assign rvalid0 = w_tag_out.vld && !w_tag_out.id;
  assign rvalid1 = w_tag_out.vld &&  w_tag_out.id;
  assign rdata   = mem_rdata;

endmodule
